// File: rtl/oled_glyph_writer.sv
// oled_glyph_writer
// Fetches one glyph (8 or 16 columns, two 8-pixel pages tall) from the font ROM
// and streams it to the OLED byte transmitter. Each half is preceded by the
// SSD1306 page-address, column-low and column-high commands.
module oled_glyph_writer #(
    parameter logic [7:0] PAGE_CMD_BASE = 8'hB0,
    parameter int         ROM_LATENCY   = 1
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_glyph,
    input  logic       req_wide,
    input  logic [2:0] req_page,
    input  logic [6:0] req_col,
    output logic [5:0] font_sel,
    output logic       font_row,
    output logic [8:0] index,
    input  logic [7:0] font_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_dc,
    output logic       busy,
    output logic       done
);

    // The FETCH/CAPTURE pair assumes exactly one cycle of ROM read latency.
    generate
        if (ROM_LATENCY != 1) begin : g_rom_latency_check
            $error("oled_glyph_writer: only ROM_LATENCY == 1 is supported");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        CMD_PAGE,
        CMD_CLO,
        CMD_CHI,
        FETCH,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    state_t     state_reg;
    state_t     state_next;

    // Request fields, frozen for the whole glyph.
    logic [5:0] glyph_reg;
    logic       wide_reg;
    logic [2:0] page_reg;
    logic [6:0] col_reg;

    // Half (row) and column-within-half counters.
    logic       row_reg;
    logic       row_next;
    logic [3:0] col_cnt_reg;
    logic [3:0] col_cnt_next;

    // Glyph byte captured from the ROM, presented during SEND.
    logic [7:0] data_reg;

    logic       accept;
    logic       last_col;
    logic [2:0] cur_page;

    assign accept   = req_valid && (state_reg == IDLE);
    assign last_col = wide_reg ? (col_cnt_reg == 4'd15) : (col_cnt_reg == 4'd7);
    // 3-bit addition wraps page 7 + 1 back to page 0.
    assign cur_page = page_reg + {2'b00, row_reg};

    // The ROM address simply follows the counters; it is stable from FETCH through CAPTURE.
    assign font_sel = glyph_reg;
    assign font_row = row_reg;
    assign index    = {5'd0, col_cnt_reg};

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the request on acceptance; req_* is ignored afterwards.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            glyph_reg <= 6'd0;
            wide_reg  <= 1'b0;
            page_reg  <= 3'd0;
            col_reg   <= 7'd0;
        end else if (accept) begin
            glyph_reg <= req_glyph;
            wide_reg  <= req_wide;
            page_reg  <= req_page;
            col_reg   <= req_col;
        end
    end

    // Row/column counters and the captured ROM byte.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg     <= 1'b0;
            col_cnt_reg <= 4'd0;
            data_reg    <= 8'd0;
        end else begin
            row_reg     <= row_next;
            col_cnt_reg <= col_cnt_next;
            if (state_reg == CAPTURE) begin
                data_reg <= font_data;
            end
        end
    end

    // Next-state, counter updates and handshake/status outputs.
    always_comb begin
        state_next   = state_reg;
        row_next     = row_reg;
        col_cnt_next = col_cnt_reg;
        req_ready    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        tx_valid     = 1'b0;
        tx_byte      = data_reg;
        tx_dc        = 1'b0;

        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (accept) begin
                    state_next   = CMD_PAGE;
                    row_next     = 1'b0;
                    col_cnt_next = 4'd0;
                end
            end
            CMD_PAGE: begin
                tx_valid = 1'b1;
                tx_byte  = PAGE_CMD_BASE + {5'd0, cur_page};
                if (tx_ready) begin
                    state_next = CMD_CLO;
                end
            end
            CMD_CLO: begin
                tx_valid = 1'b1;
                tx_byte  = {4'h0, col_reg[3:0]};
                if (tx_ready) begin
                    state_next = CMD_CHI;
                end
            end
            CMD_CHI: begin
                tx_valid = 1'b1;
                tx_byte  = {4'h1, 1'b0, col_reg[6:4]};
                if (tx_ready) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_dc    = 1'b1;
                if (tx_ready) begin
                    if (!last_col) begin
                        col_cnt_next = col_cnt_reg + 4'd1;
                        state_next   = FETCH;
                    end else if (!row_reg) begin
                        row_next     = 1'b1;
                        col_cnt_next = 4'd0;
                        state_next   = CMD_PAGE;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oled_glyph_writer.sv
// Testbench for oled_glyph_writer: a font ROM model, a queue-based reference of
// the byte stream each request must produce, and a per-cycle compare process.
module tb_oled_glyph_writer;

    localparam int PERIOD = 10;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_glyph;
    logic       req_wide;
    logic [2:0] req_page;
    logic [6:0] req_col;
    logic [5:0] font_sel;
    logic       font_row;
    logic [8:0] index;
    logic [7:0] font_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_byte;
    logic       tx_dc;
    logic       busy;
    logic       done;

    always #(PERIOD / 2) sys_clk = ~sys_clk;

    oled_glyph_writer dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_glyph (req_glyph),
        .req_wide  (req_wide),
        .req_page  (req_page),
        .req_col   (req_col),
        .font_sel  (font_sel),
        .font_row  (font_row),
        .index     (index),
        .font_data (font_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_byte   (tx_byte),
        .tx_dc     (tx_dc),
        .busy      (busy),
        .done      (done)
    );

    // Known glyph content: glyph 0 (both halves) and the first 4 columns of glyph 6.
    localparam logic [7:0] G0 [16] = '{8'h08, 8'hF8, 8'h88, 8'h88, 8'hE8, 8'h08, 8'h10, 8'h00,
                                       8'h20, 8'h3F, 8'h20, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] G6 [8]  = '{8'h10, 8'h60, 8'h02, 8'h8C,
                                       8'h04, 8'h04, 8'h7E, 8'h01};
    localparam logic [7:0] NARROW_EXP [22] = '{
        8'hB2, 8'h05, 8'h12, 8'h08, 8'hF8, 8'h88, 8'h88, 8'hE8, 8'h08, 8'h10, 8'h00,
        8'hB3, 8'h05, 8'h12, 8'h20, 8'h3F, 8'h20, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};

    function automatic logic [7:0] rom_byte(input logic [5:0] g, input logic row, input logic [8:0] idx);
        int v;
        if (g == 6'd0 && idx < 9'd8) return G0[int'(row) * 8 + int'(idx)];
        if (g == 6'd6 && idx < 9'd4) return G6[int'(row) * 4 + int'(idx)];
        v = int'(g) * 37 + int'(idx) * 13 + int'(row) * 101;
        return v[7:0] ^ 8'h5A;
    endfunction

    // Font ROM with a registered read.
    always @(posedge sys_clk) font_data <= rom_byte(font_sel, font_row, index);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state: expected {dc, byte} stream and observed history.
    logic [8:0] exp_q [$];
    logic [8:0] log_q [$];
    int         accept_cyc [$];
    int         cyc = 0;
    int         accept_cnt = 0;
    int         done_cnt = 0;
    int         data_hs = 0;
    int         busy_cycles = 0;
    logic       model_idle = 1'b1;
    logic       exp_done = 1'b0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out = 9'd0;
    logic       bp_on = 1'b0;

    task automatic push_expected(input logic [5:0] g, input logic w, input logic [2:0] p, input logic [6:0] col);
        int width;
        int pg;
        width = w ? 16 : 8;
        for (int r = 0; r < 2; r++) begin
            pg = (int'(p) + r) % 8;
            exp_q.push_back({1'b0, 8'(8'hB0 + pg)});
            exp_q.push_back({1'b0, 8'(int'(col) % 16)});
            exp_q.push_back({1'b0, 8'(16 + int'(col) / 16)});
            for (int c = 0; c < width; c++) begin
                exp_q.push_back({1'b1, rom_byte(g, r[0], 9'(c))});
            end
        end
    endtask

    // Per-cycle compare against the model; sampled on the falling edge.
    logic       nidle;
    logic       ndone;
    logic [8:0] e;
    initial begin
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                model_idle = 1'b1;
                exp_done   = 1'b0;
                prev_stall = 1'b0;
                data_hs    = 0;
            end else begin
                check("req_ready", 32'(req_ready), 32'(model_idle));
                check("busy", 32'(busy), 32'(!model_idle && !exp_done));
                check("done", 32'(done), 32'(exp_done));
                if (prev_stall) begin
                    check("stall_valid", 32'(tx_valid), 32'd1);
                    check("stall_hold", 32'({tx_dc, tx_byte}), 32'(prev_out));
                end
                if (tx_valid && exp_q.size() == 0) check("spurious_tx", 32'd1, 32'd0);
                nidle = model_idle;
                ndone = 1'b0;
                if (exp_done) begin
                    done_cnt++;
                    nidle = 1'b1;
                end
                if (busy) busy_cycles++;
                if (tx_valid && tx_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tx_out", 32'({tx_dc, tx_byte}), 32'(e));
                    log_q.push_back({tx_dc, tx_byte});
                    if (tx_dc) data_hs++;
                    if (exp_q.size() == 0) ndone = 1'b1;
                end
                if (req_valid && model_idle) begin
                    push_expected(req_glyph, req_wide, req_page, req_col);
                    log_q.delete();
                    accept_cyc.push_back(cyc);
                    accept_cnt++;
                    busy_cycles = 0;
                    data_hs = 0;
                    nidle = 1'b0;
                end
                prev_stall = tx_valid && !tx_ready;
                prev_out   = {tx_dc, tx_byte};
                model_idle = nidle;
                exp_done   = ndone;
            end
        end
    end

    // Transmitter ready: always high, or random ~50% when backpressure is enabled.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            tx_ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic wait_accept(input int target, input string what);
        int n = 0;
        while (accept_cnt < target && n < 500) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        check({what, "_accept_timeout"}, 32'(accept_cnt >= target), 32'd1);
    endtask

    task automatic wait_done(input int target, input string what);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        check({what, "_done_timeout"}, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic run_req(input logic [5:0] g, input logic w, input logic [2:0] p, input logic [6:0] c);
        int a0 = accept_cnt;
        int d0 = done_cnt;
        @(posedge sys_clk);
        #1;
        req_glyph = g;
        req_wide  = w;
        req_page  = p;
        req_col   = c;
        req_valid = 1'b1;
        wait_accept(a0 + 1, "req");
        @(posedge sys_clk);
        #1;
        req_valid = 1'b0;
        req_glyph = 6'($urandom);
        req_wide  = 1'($urandom);
        req_page  = 3'($urandom);
        req_col   = 7'($urandom);
        wait_done(d0 + 1, "req");
    endtask

    task automatic check_narrow_literal();
        logic [8:0] got;
        check("narrow_count", 32'(log_q.size()), 32'd22);
        for (int i = 0; i < 22; i++) begin
            got = (i < log_q.size()) ? log_q[i] : 9'h1FF;
            check("narrow_byte", 32'(got[7:0]), 32'(NARROW_EXP[i]));
            check("narrow_dc", 32'(got[8]), 32'((i < 3 || (i >= 11 && i < 14)) ? 0 : 1));
        end
    endtask

    task automatic check_log(input int i, input logic [7:0] exp, input string name);
        logic [8:0] got;
        got = (i < log_q.size()) ? log_q[i] : 9'h1FF;
        check(name, 32'(got[7:0]), 32'(exp));
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_font_sel", 32'(font_sel), 32'd0);
        check("rst_font_row", 32'(font_row), 32'd0);
        check("rst_index", 32'(index), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_tx_dc", 32'(tx_dc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #(PERIOD * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int d0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_glyph = 6'd0;
        req_wide  = 1'b0;
        req_page  = 3'd0;
        req_col   = 7'd0;
        #2;
        check_reset_values();
        repeat (3) @(posedge sys_clk);
        #2;
        rst_n = 1'b1;

        // Narrow glyph 0, page 2, col 0x25, no backpressure.
        run_req(6'd0, 1'b0, 3'd2, 7'h25);
        check_narrow_literal();
        check("narrow_busy_cycles", 32'(busy_cycles), 32'd54);

        // Wide glyph 6, page 0, col 0.
        run_req(6'd6, 1'b1, 3'd0, 7'd0);
        check("wide_count", 32'(log_q.size()), 32'd38);
        check("wide_busy_cycles", 32'(busy_cycles), 32'd102);
        check_log(0, 8'hB0, "wide_page0");
        check_log(1, 8'h00, "wide_clo0");
        check_log(2, 8'h10, "wide_chi0");
        check_log(3, 8'h10, "wide_d0");
        check_log(4, 8'h60, "wide_d1");
        check_log(5, 8'h02, "wide_d2");
        check_log(6, 8'h8C, "wide_d3");
        check_log(19, 8'hB1, "wide_page1");
        check_log(22, 8'h04, "wide_d16");
        check_log(25, 8'h01, "wide_d19");

        // Glyph 0 again under random backpressure.
        bp_on = 1'b1;
        run_req(6'd0, 1'b0, 3'd2, 7'h25);
        check_narrow_literal();

        // Page wrap and top column.
        run_req(6'd3, 1'b0, 3'd7, 7'h7F);
        check_log(0, 8'hB7, "wrap_page_top");
        check_log(1, 8'h0F, "wrap_clo");
        check_log(2, 8'h17, "wrap_chi");
        check_log(11, 8'hB0, "wrap_page_bottom");

        // Back-to-back: req_valid held high, fields changed while busy.
        bp_on = 1'b0;
        a0 = accept_cnt;
        d0 = done_cnt;
        @(posedge sys_clk);
        #1;
        req_glyph = 6'd0;
        req_wide  = 1'b0;
        req_page  = 3'd2;
        req_col   = 7'h25;
        req_valid = 1'b1;
        wait_accept(a0 + 1, "b2b_first");
        @(posedge sys_clk);
        #1;
        req_glyph = 6'd9;
        req_wide  = 1'b1;
        req_page  = 3'd5;
        req_col   = 7'h40;
        wait_accept(a0 + 2, "b2b_second");
        @(posedge sys_clk);
        #1;
        req_valid = 1'b0;
        wait_done(d0 + 2, "b2b");
        check("b2b_spacing", 32'(accept_cyc[$] - accept_cyc[$ - 1]), 32'd56);

        // Random requests with backpressure.
        bp_on = 1'b1;
        for (int k = 0; k < 8; k++) begin
            run_req(6'($urandom), 1'($urandom), 3'($urandom), 7'($urandom));
        end

        // Reset in the middle of a glyph, then restart.
        bp_on = 1'b0;
        a0 = accept_cnt;
        @(posedge sys_clk);
        #1;
        req_glyph = 6'd0;
        req_wide  = 1'b0;
        req_page  = 3'd2;
        req_col   = 7'h25;
        req_valid = 1'b1;
        wait_accept(a0 + 1, "mid_rst");
        @(posedge sys_clk);
        #1;
        req_valid = 1'b0;
        for (int n = 0; n < 500 && data_hs < 5; n++) begin
            @(negedge sys_clk);
            #1;
        end
        check("mid_rst_data_timeout", 32'(data_hs >= 5), 32'd1);
        @(posedge sys_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge sys_clk);
        #2;
        rst_n = 1'b1;
        run_req(6'd0, 1'b0, 3'd2, 7'h25);
        check_narrow_literal();

        repeat (3) @(posedge sys_clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
